// File: rtl/fir_sample_buffer_if.sv
// Bus between the FIR sample buffer (slave) and the sample source / MAC engine (master).
// Widths follow the buffer's DATA_W, LANES and read-address width ADDR_W.
interface fir_sample_buffer_if #(
    parameter int DATA_W = 18,
    parameter int LANES  = 8,
    parameter int ADDR_W = 12
);
    // Handshake: sample_strobe is a one-cycle valid pulse with no ready/backpressure; the
    // buffer accepts it only when idle (or in the mac_done cycle) and otherwise drops it and
    // sets the sticky overrun. datain_ready is a one-cycle pulse per committed sample;
    // mac_done is a one-cycle pulse ending the frame. Reads return data one cycle after addr_data.
    logic [DATA_W-1:0]       sample_in;
    logic                    sample_strobe;
    logic [ADDR_W-1:0]       addr_data;
    logic [LANES*DATA_W-1:0] datain;
    logic                    datain_ready;
    logic                    mac_done;
    logic                    overrun;
    logic                    busy;

    modport master (
        output sample_in, sample_strobe, addr_data, mac_done,
        input  datain, datain_ready, overrun, busy
    );

    modport slave (
        input  sample_in, sample_strobe, addr_data, mac_done,
        output datain, datain_ready, overrun, busy
    );
endinterface

// File: rtl/fir_sample_buffer.sv
// Banked circular sample history feeding an 8-lane FIR MAC engine, frozen while a frame runs.
// Optional FIR_BUF_CLEAR_EN: zero the whole history after reset via a CLEAR state.
module fir_sample_buffer #(
    parameter int DATA_W = 18,
    parameter int LANES  = 8,
    parameter int WORDS  = 2048
) (
    input  logic                 clock,
    input  logic                 reset,
    fir_sample_buffer_if.slave   bus,
    output logic [1:0]           state_dbg
);
    localparam int PTR_W  = $clog2(LANES * WORDS);
    localparam int BANK_W = $clog2(LANES);
    localparam int ROW_W  = $clog2(WORDS);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        NOTIFY = 2'd2,
        BUSY   = 2'd3
    } state_t;

`ifdef FIR_BUF_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    logic [ROW_W-1:0] clr_row;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state;
    logic [PTR_W-1:0]  wp;
    logic              ready_q;
    logic              busy_q;
    logic              overrun_q;
    logic              commit;

    logic [PTR_W-1:0]  n_ptr;
    logic [BANK_W-1:0] n_bank;
    logic [ROW_W-1:0]  n_row;
    logic [ROW_W-1:0]  addr_row;
    logic [BANK_W-1:0] rot_q;
    logic [DATA_W-1:0] bank_rd [LANES];
    logic [LANES*DATA_W-1:0] datain_c;

    // A strobe is taken in IDLE, or in BUSY when it coincides with mac_done.
    assign commit = bus.sample_strobe && ((state == IDLE) || ((state == BUSY) && bus.mac_done));

    assign n_ptr    = wp - PTR_W'(1);
    assign n_bank   = n_ptr[BANK_W-1:0];
    assign n_row    = n_ptr[PTR_W-1:BANK_W];
    assign addr_row = bus.addr_data[ROW_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            wp        <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef FIR_BUF_CLEAR_EN
            clr_row   <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state)
`ifdef FIR_BUF_CLEAR_EN
                CLEAR: begin
                    clr_row <= clr_row + 1'b1;
                    if (bus.sample_strobe) overrun_q <= 1'b1;
                    if (clr_row == ROW_W'(WORDS - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
`endif
                IDLE: begin
                    if (bus.sample_strobe) begin
                        wp      <= wp + 1'b1;
                        state   <= NOTIFY;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                NOTIFY: begin
                    state <= BUSY;
                    if (bus.sample_strobe) overrun_q <= 1'b1;
                end
                BUSY: begin
                    if (bus.mac_done) begin
                        if (bus.sample_strobe) begin
                            wp      <= wp + 1'b1;
                            state   <= NOTIFY;
                            ready_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (bus.sample_strobe) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane j of word k lives in bank (n-j) mod LANES; banks above n_bank belong to the previous row.
    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_W-1:0] mem [WORDS];
        logic [DATA_W-1:0] q;
        logic [ROW_W-1:0]  rd_row;
        logic              row_borrow;

        assign row_borrow = (BANK_W'(b) > n_bank);
        assign rd_row     = n_row - addr_row - {{(ROW_W-1){1'b0}}, row_borrow};

        always_ff @(posedge clock) begin
`ifdef FIR_BUF_CLEAR_EN
            if (state == CLEAR) begin
                mem[clr_row] <= '0;
            end else if (commit && (wp[BANK_W-1:0] == BANK_W'(b))) begin
                mem[wp[PTR_W-1:BANK_W]] <= bus.sample_in;
            end
`else
            if (commit && (wp[BANK_W-1:0] == BANK_W'(b))) begin
                mem[wp[PTR_W-1:BANK_W]] <= bus.sample_in;
            end
`endif
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) q <= '0;
            else        q <= mem[rd_row];
        end

        assign bank_rd[b] = q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rot_q <= '0;
        else        rot_q <= n_bank;
    end

    // Lane 0 (newest) sits in the top slice, lane LANES-1 (oldest) in the bottom slice.
    always_comb begin
        datain_c = '0;
        for (int j = 0; j < LANES; j++) begin
            datain_c[(LANES - j) * DATA_W - 1 -: DATA_W] = bank_rd[rot_q - BANK_W'(j)];
        end
    end

    assign bus.datain       = datain_c;
    assign bus.datain_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
    assign state_dbg        = state;
endmodule

// File: tb/tb_fir_sample_buffer.sv
// Directed self-checking bench for fir_sample_buffer with hand-computed read words.
// Works with or without FIR_BUF_CLEAR_EN (without it the history is first filled with zeros).
module tb_fir_sample_buffer;
    localparam int DATA_W = 18;
    localparam int LANES  = 8;
    localparam int WORDS  = 2048;
    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_NOTIFY = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    logic       clock;
    logic       reset;
    logic [1:0] state_dbg;
    int         checks;
    int         errors;
    logic [DATA_W-1:0] exp_q[$];

    fir_sample_buffer_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(12)) bus ();

    fir_sample_buffer #(.DATA_W(DATA_W), .LANES(LANES), .WORDS(WORDS)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] lane_of(input logic [LANES*DATA_W-1:0] w, input int j);
        return w[(LANES - j) * DATA_W - 1 -: DATA_W];
    endfunction

    task automatic exp_word(input int l0, input int l1, input int l2, input int l3,
                            input int l4, input int l5, input int l6, input int l7);
        exp_q.push_back(DATA_W'(l0)); exp_q.push_back(DATA_W'(l1));
        exp_q.push_back(DATA_W'(l2)); exp_q.push_back(DATA_W'(l3));
        exp_q.push_back(DATA_W'(l4)); exp_q.push_back(DATA_W'(l5));
        exp_q.push_back(DATA_W'(l6)); exp_q.push_back(DATA_W'(l7));
    endtask

    // driver tasks: all are entered and left at a falling edge
    task automatic read_word(input logic [11:0] addr);
        logic [DATA_W-1:0] e;
        bus.addr_data = addr;
        @(negedge clock);
        for (int j = 0; j < LANES; j++) begin
            e = exp_q.pop_front();
            check($sformatf("rd%0h_lane%0d", addr, j), 32'(lane_of(bus.datain, j)), 32'(e));
        end
    endtask

    task automatic commit_one(input int v);
        bus.sample_strobe = 1'b1;
        bus.sample_in     = DATA_W'(v);
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        check($sformatf("ready_pulse_%0d", v), 32'(bus.datain_ready), 32'd1);
        @(negedge clock);
        check($sformatf("ready_drop_%0d", v), 32'(bus.datain_ready), 32'd0);
        check($sformatf("busy_%0d", v), 32'(bus.busy), 32'd1);
        check($sformatf("state_busy_%0d", v), 32'(state_dbg), 32'(ST_BUSY));
        bus.mac_done = 1'b1;
        @(negedge clock);
        bus.mac_done = 1'b0;
        check($sformatf("state_idle_%0d", v), 32'(state_dbg), 32'(ST_IDLE));
        check($sformatf("busy_clr_%0d", v), 32'(bus.busy), 32'd0);
    endtask

    // Back-to-back commits: each later strobe rides on the mac_done of the previous frame.
    task automatic bulk(input int count, input bit use_index);
        for (int i = 0; i < count; i++) begin
            bus.sample_strobe = 1'b1;
            bus.sample_in     = use_index ? DATA_W'(i) : '0;
            bus.mac_done      = (i != 0);
            @(negedge clock);
            bus.sample_strobe = 1'b0;
            bus.mac_done      = 1'b0;
            @(negedge clock);
        end
        bus.mac_done = 1'b1;
        @(negedge clock);
        bus.mac_done = 1'b0;
        @(negedge clock);
        check("bulk_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("bulk_overrun", 32'(bus.overrun), 32'd0);
    endtask

    task automatic wait_clear(input string tag);
`ifdef FIR_BUF_CLEAR_EN
        @(negedge clock);
        @(negedge clock);
        check({tag, "_clear_state"}, 32'(state_dbg), 32'(ST_CLEAR));
        check({tag, "_clear_busy"}, 32'(bus.busy), 32'd1);
        repeat (WORDS + 2) @(negedge clock);
`endif
        check({tag, "_idle_state"}, 32'(state_dbg), 32'(ST_IDLE));
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int saw_ready;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.sample_in = '0;
        bus.sample_strobe = 1'b0;
        bus.addr_data = '0;
        bus.mac_done = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_datain", 32'(|bus.datain), 32'd0);
        check("rst_ready", 32'(bus.datain_ready), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        wait_clear("boot");
`ifndef FIR_BUF_CLEAR_EN
        bulk(LANES * WORDS, 1'b0);
`endif

        // first sample into an all-zero history
        commit_one(1);
        exp_word(1, 0, 0, 0, 0, 0, 0, 0);
        read_word(12'h000);
        check("first_overrun", 32'(bus.overrun), 32'd0);

        // ten samples 1..10 in total
        for (int v = 2; v <= 10; v++) commit_one(v);
        exp_word(10, 9, 8, 7, 6, 5, 4, 3);
        read_word(12'h000);
        exp_word(2, 1, 0, 0, 0, 0, 0, 0);
        read_word(12'h001);

        // mac_done outside BUSY is ignored
        bus.mac_done = 1'b1;
        @(negedge clock);
        bus.mac_done = 1'b0;
        check("idle_done_state", 32'(state_dbg), 32'(ST_IDLE));
        check("idle_done_ready", 32'(bus.datain_ready), 32'd0);

        // strobe coinciding with mac_done is committed
        bus.sample_strobe = 1'b1;
        bus.sample_in = 18'd11;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        @(negedge clock);
        bus.sample_strobe = 1'b1;
        bus.sample_in = 18'd12;
        bus.mac_done = 1'b1;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        bus.mac_done = 1'b0;
        check("same_cycle_ready", 32'(bus.datain_ready), 32'd1);
        check("same_cycle_state", 32'(state_dbg), 32'(ST_NOTIFY));
        check("same_cycle_overrun", 32'(bus.overrun), 32'd0);
        @(negedge clock);
        bus.mac_done = 1'b1;
        @(negedge clock);
        bus.mac_done = 1'b0;
        exp_word(12, 11, 10, 9, 8, 7, 6, 5);
        read_word(12'h000);

        // strobe during BUSY is dropped and overrun sticks
        bus.sample_strobe = 1'b1;
        bus.sample_in = 18'd13;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        @(negedge clock);
        bus.sample_strobe = 1'b1;
        bus.sample_in = 18'd99;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        check("drop_overrun", 32'(bus.overrun), 32'd1);
        check("drop_state", 32'(state_dbg), 32'(ST_BUSY));
        check("drop_ready", 32'(bus.datain_ready), 32'd0);
        bus.mac_done = 1'b1;
        @(negedge clock);
        bus.mac_done = 1'b0;
        exp_word(13, 12, 11, 10, 9, 8, 7, 6);
        read_word(12'h000);
        commit_one(14);
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        exp_word(14, 13, 12, 11, 10, 9, 8, 7);
        read_word(12'h000);

        // reset in the middle of a frame
        bus.sample_strobe = 1'b1;
        bus.sample_in = 18'd15;
        @(negedge clock);
        bus.sample_strobe = 1'b0;
        @(negedge clock);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_datain", 32'(|bus.datain), 32'd0);
        check("midrst_ready", 32'(bus.datain_ready), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        saw_ready = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.datain_ready) saw_ready++;
        end
        check("post_rst_no_ready", 32'(saw_ready), 32'd0);
`ifdef FIR_BUF_CLEAR_EN
        check("post_rst_state", 32'(state_dbg), 32'(ST_CLEAR));
        repeat (WORDS) @(negedge clock);
`else
        check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));
`endif
        check("post_rst_idle", 32'(state_dbg), 32'(ST_IDLE));

        // pointer wrap: samples k = 0..16389
        bulk(16390, 1'b1);
        exp_word(16389, 16388, 16387, 16386, 16385, 16384, 16383, 16382);
        read_word(12'h000);
        exp_word(13, 12, 11, 10, 9, 8, 7, 6);
        read_word(12'h7FF);
        exp_word(16389, 16388, 16387, 16386, 16385, 16384, 16383, 16382);
        read_word(12'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
